// File: rtl/puf_meas_ctrl.sv
// puf_meas_ctrl: measurement sequencer for the ring-oscillator PUF.
// Per pair: clear counters, run the RO window, settle, compare counts and store one bit.
module puf_meas_ctrl #(
  parameter int unsigned CNT_BIT_SIZE = 5,
  parameter int unsigned N_BITS       = 8,
  parameter int unsigned WIN_CYCLES   = 64,
  parameter int unsigned GUARD_CYCLES = 4,
  localparam int unsigned IDX_W       = ($clog2(N_BITS) > 1) ? $clog2(N_BITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic                    i_valid_a,
  input  logic                    i_valid_b,
  input  logic [CNT_BIT_SIZE-1:0] i_count_a,
  input  logic [CNT_BIT_SIZE-1:0] i_count_b,
  output logic                    o_ro_en,
  output logic                    o_cnt_rst_n,
  output logic [IDX_W-1:0]        o_pair_idx,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_resp_valid,
  output logic [N_BITS-1:0]       o_response,
  output logic                    o_tie
);

  localparam int unsigned WIN_W = $clog2(WIN_CYCLES + 1);
  localparam int unsigned GRD_W = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_GUARD   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    pair_idx_q, pair_idx_d;
  logic [N_BITS-1:0]   response_q, response_d;
  logic                tie_q, tie_d;
  logic                resp_valid_q, resp_valid_d;
  logic                ro_en_q, ro_en_d;
  logic                cnt_rst_n_q, cnt_rst_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [GRD_W-1:0]    grd_cnt_q, grd_cnt_d;
  logic                clr_cnt_q, clr_cnt_d;
  logic [1:0]          sync_a_q, sync_a_d;
  logic [1:0]          sync_b_q, sync_b_d;

  // Next-state, datapath updates and registered-output values
  always_comb begin
    state_d      = state_q;
    pair_idx_d   = pair_idx_q;
    response_d   = response_q;
    tie_d        = tie_q;
    resp_valid_d = resp_valid_q;
    win_cnt_d    = '0;
    grd_cnt_d    = '0;
    clr_cnt_d    = 1'b0;
    sync_a_d     = {sync_a_q[0], i_valid_a};
    sync_b_d     = {sync_b_q[0], i_valid_b};

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          pair_idx_d   = '0;
          response_d   = '0;
          tie_d        = 1'b0;
          resp_valid_d = 1'b0;
          state_d      = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q) state_d = ST_RUN;
        else           clr_cnt_d = 1'b1;
      end
      ST_RUN: begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        // Window expiry or both counters reporting complete ends the window
        if ((win_cnt_q == WIN_W'(WIN_CYCLES - 1)) || (sync_a_q[1] && sync_b_q[1])) begin
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        grd_cnt_d = grd_cnt_q + GRD_W'(1);
        if (grd_cnt_q == GRD_W'(GUARD_CYCLES - 1)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        response_d[pair_idx_q] = (i_count_a > i_count_b);
        tie_d                  = tie_q | (i_count_a == i_count_b);
        state_d                = ST_NEXT;
      end
      ST_NEXT: begin
        if (pair_idx_q == IDX_W'(N_BITS - 1)) begin
          resp_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          pair_idx_d = pair_idx_q + IDX_W'(1);
          state_d    = ST_CLEAR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything; partial response, tie and index are kept
    if (i_abort) begin
      state_d      = ST_IDLE;
      pair_idx_d   = pair_idx_q;
      response_d   = response_q;
      tie_d        = tie_q;
      resp_valid_d = 1'b0;
      win_cnt_d    = '0;
      grd_cnt_d    = '0;
      clr_cnt_d    = 1'b0;
    end

    ro_en_d     = (state_d == ST_RUN);
    cnt_rst_n_d = (state_d != ST_CLEAR);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // State, counters, synchronizers and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pair_idx_q   <= '0;
      response_q   <= '0;
      tie_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      ro_en_q      <= 1'b0;
      cnt_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      win_cnt_q    <= '0;
      grd_cnt_q    <= '0;
      clr_cnt_q    <= 1'b0;
      sync_a_q     <= '0;
      sync_b_q     <= '0;
    end else begin
      state_q      <= state_d;
      pair_idx_q   <= pair_idx_d;
      response_q   <= response_d;
      tie_q        <= tie_d;
      resp_valid_q <= resp_valid_d;
      ro_en_q      <= ro_en_d;
      cnt_rst_n_q  <= cnt_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      win_cnt_q    <= win_cnt_d;
      grd_cnt_q    <= grd_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      sync_a_q     <= sync_a_d;
      sync_b_q     <= sync_b_d;
    end
  end

  assign o_ro_en      = ro_en_q;
  assign o_cnt_rst_n  = cnt_rst_n_q;
  assign o_pair_idx   = pair_idx_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_resp_valid = resp_valid_q;
  assign o_response   = response_q;
  assign o_tie        = tie_q;

endmodule
